// File: rtl/r16_s2p_collector_pkg.sv
// Shared constants for the radix-16 serial-to-parallel collector and its lane mux.
`ifndef D_width
`define D_width 64
`endif

package r16_s2p_collector_pkg;
    localparam int R16_LANES       = 16;
    localparam int R16_CNT_W       = 4;
    localparam int R16_GRP_W_DEF   = 8;
    localparam int R16_D_WIDTH_DEF = `D_width;
endpackage

// File: rtl/r16_s2p_collector_if.sv
// Serial sample input and 16-lane parallel group output of the R16 collector.
interface r16_s2p_collector_if
    import r16_s2p_collector_pkg::*;
#(
    parameter int D_WIDTH = R16_D_WIDTH_DEF,
    parameter int GRP_W   = R16_GRP_W_DEF
);
    logic               in_valid;
    logic [D_WIDTH-1:0] in_data;
    logic               in_last;

    logic [D_WIDTH-1:0] data_out [R16_LANES];
    logic               out_valid;
    logic               out_last;
    logic [GRP_W-1:0]   out_grp_idx;

    modport master (
        output in_valid, in_data, in_last,
        input  data_out, out_valid, out_last, out_grp_idx
    );

    modport slave (
        input  in_valid, in_data, in_last,
        output data_out, out_valid, out_last, out_grp_idx
    );
endinterface

// File: rtl/r16_s2p_collector_lane_mux.sv
// Next-lane values for a completing group: staged lanes below wr_cnt, the live
// sample bypassed into lane wr_cnt, and zero padding above it.
module r16_lane_mux
    import r16_s2p_collector_pkg::*;
#(
    parameter int D_WIDTH = R16_D_WIDTH_DEF
) (
    input  logic [D_WIDTH-1:0]   staging [R16_LANES-1],
    input  logic [R16_CNT_W-1:0] wr_cnt,
    input  logic [D_WIDTH-1:0]   in_data,
    output logic [D_WIDTH-1:0]   lanes   [R16_LANES]
);
    for (genvar gi = 0; gi < R16_LANES; gi++) begin : g_lane
        localparam logic [R16_CNT_W-1:0] LANE_IDX = R16_CNT_W'(gi);
        if (gi < R16_LANES - 1) begin : g_staged
            assign lanes[gi] = (LANE_IDX < wr_cnt)  ? staging[gi] :
                               (LANE_IDX == wr_cnt) ? in_data     : '0;
        end else begin : g_top
            // The top lane is only ever filled by the bypass path.
            assign lanes[gi] = (LANE_IDX == wr_cnt) ? in_data : '0;
        end
    end
endmodule

// File: rtl/r16_s2p_collector.sv
// Collects serial samples into groups of 16 and presents each group on registered
// parallel lanes with a one-cycle valid pulse, group index and frame-end flag.
module r16_s2p_collector
    import r16_s2p_collector_pkg::*;
#(
    parameter int D_WIDTH = R16_D_WIDTH_DEF,
    parameter int LANES   = R16_LANES,
    parameter int GRP_W   = R16_GRP_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    r16_s2p_collector_if.slave bus
);
    localparam logic [R16_CNT_W-1:0] CNT_MAX = R16_CNT_W'(LANES - 1);

    logic [R16_CNT_W-1:0] wr_cnt_q,    wr_cnt_d;
    logic [GRP_W-1:0]     grp_cnt_q,   grp_cnt_d;
    logic [GRP_W-1:0]     grp_idx_q,   grp_idx_d;
    logic                 out_valid_q, out_valid_d;
    logic                 out_last_q,  out_last_d;
    logic [D_WIDTH-1:0]   staging_q [LANES-1];
    logic [D_WIDTH-1:0]   staging_d [LANES-1];
    logic [D_WIDTH-1:0]   lanes_q   [LANES];
    logic [D_WIDTH-1:0]   lanes_d   [LANES];
    logic [D_WIDTH-1:0]   mux_lanes [LANES];
    logic                 grp_done;

    r16_lane_mux #(
        .D_WIDTH (D_WIDTH)
    ) u_lane_mux (
        .staging (staging_q),
        .wr_cnt  (wr_cnt_q),
        .in_data (bus.in_data),
        .lanes   (mux_lanes)
    );

    assign grp_done = bus.in_valid && (bus.in_last || wr_cnt_q == CNT_MAX);

    always_comb begin
        wr_cnt_d    = wr_cnt_q;
        grp_cnt_d   = grp_cnt_q;
        grp_idx_d   = grp_idx_q;
        out_valid_d = 1'b0;
        out_last_d  = out_last_q;
        staging_d   = staging_q;
        lanes_d     = lanes_q;
        if (grp_done) begin
            lanes_d     = mux_lanes;
            out_valid_d = 1'b1;
            out_last_d  = bus.in_last;
            grp_idx_d   = grp_cnt_q;
            wr_cnt_d    = '0;
            grp_cnt_d   = bus.in_last ? '0 : grp_cnt_q + GRP_W'(1);
        end else if (bus.in_valid) begin
            // Staging is never cleared; the mux pads stale slots with zero.
            staging_d[wr_cnt_q] = bus.in_data;
            wr_cnt_d            = wr_cnt_q + R16_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_cnt_q    <= '0;
            grp_cnt_q   <= '0;
            grp_idx_q   <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            wr_cnt_q    <= wr_cnt_d;
            grp_cnt_q   <= grp_cnt_d;
            grp_idx_q   <= grp_idx_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
        end
    end

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane_reg
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                lanes_q[gi] <= '0;
            end else begin
                lanes_q[gi] <= lanes_d[gi];
            end
        end
        assign bus.data_out[gi] = lanes_q[gi];
    end

    for (genvar gi = 0; gi < LANES - 1; gi++) begin : g_stage_reg
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                staging_q[gi] <= '0;
            end else begin
                staging_q[gi] <= staging_d[gi];
            end
        end
    end

    assign bus.out_valid   = out_valid_q;
    assign bus.out_last    = out_last_q;
    assign bus.out_grp_idx = grp_idx_q;
endmodule
